// File: rtl/block_move_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// block_move_ctrl_pkg
// Shared constants for the falling-piece move controller: position field
// widths, spawn coordinates, FSM state encoding and the request-vector
// layout used to turn button/gravity pulses into one-hot move requests.
// ---------------------------------------------------------------------------
package block_move_ctrl_pkg;

    localparam int BITS_X_POS = 4;
    localparam int BITS_Y_POS = 5;
    localparam int BITS_ROT   = 2;

    localparam logic [BITS_X_POS-1:0] SPAWN_X = BITS_X_POS'(4);
    localparam logic [BITS_Y_POS-1:0] SPAWN_Y = BITS_Y_POS'(0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SPAWN  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_DROP   = 3'd3,
        ST_LOCK   = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    // Bit positions inside the request vector. Lower index = higher priority.
    localparam int REQ_FALL  = 0;
    localparam int REQ_DOWN  = 1;
    localparam int REQ_LEFT  = 2;
    localparam int REQ_RIGHT = 3;
    localparam int REQ_ROT   = 4;
    localparam int REQ_DROP  = 5;
    localparam int NUM_REQ   = 6;

    // Keep only the lowest set bit: x & (-x) in two's complement.
    function automatic logic [NUM_REQ-1:0] lowest_one_hot(input logic [NUM_REQ-1:0] raw);
        return raw & (~raw + NUM_REQ'(1));
    endfunction

endpackage

// File: rtl/block_move_ctrl_fall_timer.sv
// ---------------------------------------------------------------------------
// fall_timer
// Gravity counter. Advances once per cycle while `run` is high and raises
// `tick` (combinational) in the cycle the count sits at FALL_TICKS-1; the
// count returns to zero on that edge. `clear` forces the count to zero.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   run         count enable
//   clear       synchronous clear (takes precedence)
//   tick        gravity step request
// ---------------------------------------------------------------------------
module fall_timer #(
    parameter int FALL_TICKS = 25_000_000,
    parameter int TICK_W     = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam logic [TICK_W-1:0] LAST_COUNT = TICK_W'(FALL_TICKS - 1);

    logic [TICK_W-1:0] count_q;
    logic [TICK_W-1:0] count_d;

    assign tick = run && (count_q == LAST_COUNT);

    always_comb begin
        count_d = count_q;
        if (clear || tick) begin
            count_d = '0;
        end else if (run) begin
            count_d = count_q + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/block_move_ctrl.sv
// ---------------------------------------------------------------------------
// block_move_ctrl
// Owns the committed position of the falling piece. Button pulses and the
// gravity tick become one-hot move requests (one cycle each) for the
// test-position stage; the checker's test_ok verdict in that cycle decides
// whether the move is committed, dropped, or (for a failed fall) locks it.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   spawn                       new piece enters (accepted only in IDLE)
//   btn_left/right/down/rotate/drop  debounced one-cycle pulses
//   test_ok                     checker verdict for the current test position
//   fall_en..drop_en            registered one-hot move requests
//   ctrl_pos_x/y, ctrl_rot      committed position and rotation
//   lock                        one-cycle pulse: piece settled
//   active                      piece in play (SPAWN, ACTIVE, DROP)
//   game_over                   sticky until reset
// ---------------------------------------------------------------------------
module block_move_ctrl
    import block_move_ctrl_pkg::*;
#(
    parameter int FALL_TICKS = 25_000_000,
    parameter int TICK_W     = 25
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spawn,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_down,
    input  logic                  btn_rotate,
    input  logic                  btn_drop,
    input  logic                  test_ok,
    output logic                  fall_en,
    output logic                  left_en,
    output logic                  right_en,
    output logic                  down_en,
    output logic                  rotate_en,
    output logic                  drop_en,
    output logic [BITS_X_POS-1:0] ctrl_pos_x,
    output logic [BITS_Y_POS-1:0] ctrl_pos_y,
    output logic [BITS_ROT-1:0]   ctrl_rot,
    output logic                  lock,
    output logic                  active,
    output logic                  game_over
);

    state_t                state_q, state_d;
    logic [NUM_REQ-1:0]    req_q, req_d;
    logic [BITS_X_POS-1:0] pos_x_q, pos_x_d;
    logic [BITS_Y_POS-1:0] pos_y_q, pos_y_d;
    logic [BITS_ROT-1:0]   rot_q, rot_d;

    logic in_flight;
    logic timer_run;
    logic timer_clear;
    logic tick;
    logic [NUM_REQ-1:0] raw_req;

    // A request is in flight during its single enable cycle; nothing new
    // is accepted and gravity is frozen until it resolves.
    assign in_flight = |req_q;
    assign timer_run = (state_q == ST_ACTIVE) && !in_flight;
    assign raw_req   = {btn_drop, btn_rotate, btn_right, btn_left, btn_down, tick};

    fall_timer #(
        .FALL_TICKS (FALL_TICKS),
        .TICK_W     (TICK_W)
    ) u_fall_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (timer_run),
        .clear (timer_clear),
        .tick  (tick)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = '0;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        rot_d       = rot_q;
        timer_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (spawn) begin
                    pos_x_d     = SPAWN_X;
                    pos_y_d     = SPAWN_Y;
                    rot_d       = '0;
                    timer_clear = 1'b1;
                    state_d     = ST_SPAWN;
                end
            end

            // Enables are low here, so test_ok judges the spawn position.
            ST_SPAWN: begin
                state_d = test_ok ? ST_ACTIVE : ST_OVER;
            end

            ST_ACTIVE: begin
                if (!in_flight) begin
                    req_d = lowest_one_hot(raw_req);
                end else if (req_q[REQ_FALL] || req_q[REQ_DOWN]) begin
                    if (test_ok) begin
                        pos_y_d     = pos_y_q + BITS_Y_POS'(1);
                        timer_clear = req_q[REQ_DOWN];
                    end else begin
                        state_d = ST_LOCK;
                    end
                end else if (req_q[REQ_LEFT]) begin
                    if (test_ok) pos_x_d = pos_x_q - BITS_X_POS'(1);
                end else if (req_q[REQ_RIGHT]) begin
                    if (test_ok) pos_x_d = pos_x_q + BITS_X_POS'(1);
                end else if (req_q[REQ_ROT]) begin
                    if (test_ok) rot_d = rot_q + BITS_ROT'(1);
                end else begin
                    // Hard drop: fall_en is held for every DROP cycle.
                    state_d         = ST_DROP;
                    req_d[REQ_FALL] = 1'b1;
                end
            end

            ST_DROP: begin
                if (test_ok) begin
                    pos_y_d         = pos_y_q + BITS_Y_POS'(1);
                    req_d[REQ_FALL] = 1'b1;
                end else begin
                    state_d = ST_LOCK;
                end
            end

            ST_LOCK: begin
                state_d = ST_IDLE;
            end

            ST_OVER: begin
                state_d = ST_OVER;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            pos_x_q <= '0;
            pos_y_q <= '0;
            rot_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            rot_q   <= rot_d;
        end
    end

    assign fall_en    = req_q[REQ_FALL];
    assign down_en    = req_q[REQ_DOWN];
    assign left_en    = req_q[REQ_LEFT];
    assign right_en   = req_q[REQ_RIGHT];
    assign rotate_en  = req_q[REQ_ROT];
    assign drop_en    = req_q[REQ_DROP];
    assign ctrl_pos_x = pos_x_q;
    assign ctrl_pos_y = pos_y_q;
    assign ctrl_rot   = rot_q;
    assign lock       = (state_q == ST_LOCK);
    assign active     = (state_q == ST_SPAWN) || (state_q == ST_ACTIVE) || (state_q == ST_DROP);
    assign game_over  = (state_q == ST_OVER);

endmodule

// File: tb/tb_block_move_ctrl.sv
// ---------------------------------------------------------------------------
// tb_block_move_ctrl
// Directed scenarios with literal expectations, followed by randomized
// stimulus. A behavioural model of the piece (phase, pending move, gravity
// progress, modulo position arithmetic) is compared against every output on
// every falling clock edge.
// ---------------------------------------------------------------------------
module tb_block_move_ctrl;
    import block_move_ctrl_pkg::*;

    localparam int FT = 4;
    localparam int TW = 3;

    // model phases and move kinds (index = enable bit)
    localparam int P_IDLE = 0, P_SPAWN = 1, P_PLAY = 2, P_DROP = 3, P_LOCK = 4, P_OVER = 5;
    localparam int MV_NONE = -1, MV_FALL = 0, MV_DOWN = 1, MV_LEFT = 2, MV_RIGHT = 3, MV_ROT = 4, MV_DROP = 5;
    // checker behaviour
    localparam int OK_ALWAYS = 0, OK_NEVER = 1, OK_RANDOM = 2, OK_FLOOR = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic spawn = 1'b0;
    logic btn_left = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_rotate = 1'b0, btn_drop = 1'b0;
    logic test_ok;
    logic fall_en, left_en, right_en, down_en, rotate_en, drop_en;
    logic [BITS_X_POS-1:0] ctrl_pos_x;
    logic [BITS_Y_POS-1:0] ctrl_pos_y;
    logic [BITS_ROT-1:0]   ctrl_rot;
    logic lock, active, game_over;

    int   ok_mode = OK_ALWAYS;
    logic rnd_ok = 1'b1;
    int   floor_row = 5;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    logic [5:0] en_v;
    assign en_v = {drop_en, rotate_en, right_en, left_en, down_en, fall_en};

    block_move_ctrl #(.FALL_TICKS(FT), .TICK_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spawn      (spawn),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_down   (btn_down),
        .btn_rotate (btn_rotate),
        .btn_drop   (btn_drop),
        .test_ok    (test_ok),
        .fall_en    (fall_en),
        .left_en    (left_en),
        .right_en   (right_en),
        .down_en    (down_en),
        .rotate_en  (rotate_en),
        .drop_en    (drop_en),
        .ctrl_pos_x (ctrl_pos_x),
        .ctrl_pos_y (ctrl_pos_y),
        .ctrl_rot   (ctrl_rot),
        .lock       (lock),
        .active     (active),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Collision checker stand-in. Floor mode: legal iff the tested row
    // (committed row, +1 when a fall/down is requested) is at or above floor_row.
    always_comb begin
        test_ok = 1'b1;
        case (ok_mode)
            OK_NEVER:  test_ok = 1'b0;
            OK_RANDOM: test_ok = rnd_ok;
            OK_FLOOR:  test_ok = ((int'(ctrl_pos_y) + ((fall_en || down_en) ? 1 : 0)) <= floor_row);
            default:   test_ok = 1'b1;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_phase = P_IDLE, m_x = 0, m_y = 0, m_rot = 0, m_move = MV_NONE, m_grav = 0;

    task automatic model_reset();
        m_phase = P_IDLE; m_x = 0; m_y = 0; m_rot = 0; m_move = MV_NONE; m_grav = 0;
    endtask

    task automatic model_advance();
        logic [5:0] want;
        int pick;
        want = {btn_drop, btn_rotate, btn_right, btn_left, btn_down, 1'b0};
        case (m_phase)
            P_IDLE: if (spawn) begin
                m_x = 4; m_y = 0; m_rot = 0; m_grav = 0; m_phase = P_SPAWN;
            end
            P_SPAWN: m_phase = test_ok ? P_PLAY : P_OVER;
            P_PLAY: begin
                if (m_move == MV_NONE) begin
                    if (m_grav == FT - 1) begin
                        m_move = MV_FALL;
                        m_grav = 0;
                    end else begin
                        m_grav++;
                        pick = MV_NONE;
                        for (int k = 5; k >= 1; k--) if (want[k]) pick = k;
                        m_move = pick;
                    end
                end else begin
                    if (m_move == MV_DROP) m_phase = P_DROP;
                    else if (test_ok) begin
                        case (m_move)
                            MV_FALL, MV_DOWN: m_y = (m_y + 1) % 32;
                            MV_LEFT:  m_x = (m_x + 15) % 16;
                            MV_RIGHT: m_x = (m_x + 1) % 16;
                            default:  m_rot = (m_rot + 1) % 4;
                        endcase
                        if (m_move == MV_DOWN) m_grav = 0;
                    end else if (m_move == MV_FALL || m_move == MV_DOWN) m_phase = P_LOCK;
                    m_move = MV_NONE;
                end
            end
            P_DROP: if (test_ok) m_y = (m_y + 1) % 32; else m_phase = P_LOCK;
            P_LOCK: m_phase = P_IDLE;
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        logic [5:0] exp_en;
        if (!rst_n) model_reset();
        exp_en = '0;
        if (m_phase == P_PLAY && m_move != MV_NONE) exp_en[m_move] = 1'b1;
        if (m_phase == P_DROP) exp_en[MV_FALL] = 1'b1;
        check("model_x",   32'(ctrl_pos_x), 32'(m_x));
        check("model_y",   32'(ctrl_pos_y), 32'(m_y));
        check("model_rot", 32'(ctrl_rot),   32'(m_rot));
        check("model_en",  32'(en_v),       32'(exp_en));
        check("model_lock",   32'(lock),      32'(m_phase == P_LOCK));
        check("model_active", 32'(active),    32'(m_phase == P_SPAWN || m_phase == P_PLAY || m_phase == P_DROP));
        check("model_over",   32'(game_over), 32'(m_phase == P_OVER));
        if (rst_n) model_advance();
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int k, input logic v);
        case (k)
            MV_DOWN:  btn_down = v;
            MV_LEFT:  btn_left = v;
            MV_RIGHT: btn_right = v;
            MV_ROT:   btn_rotate = v;
            default:  btn_drop = v;
        endcase
    endtask

    // Press until the move's enable appears (a gravity tick may win instead).
    task automatic press_move(input int k);
        bit done;
        done = 0;
        for (int t = 0; t < 8 && !done; t++) begin
            set_btn(k, 1'b1);
            step();
            set_btn(k, 1'b0);
            if (en_v[k]) done = 1;
            step();
        end
        if (!done) check("press_timeout", 0, 1);
    endtask

    task automatic wait_fall(output int at);
        int n;
        n = 0;
        while (!fall_en && n < 30) begin
            step();
            n++;
        end
        if (!fall_en) check("fall_timeout", 0, 1);
        at = cyc;
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, "_x"}, 32'(ctrl_pos_x), 0);
        check({tag, "_y"}, 32'(ctrl_pos_y), 0);
        check({tag, "_rot"}, 32'(ctrl_rot), 0);
        check({tag, "_en"}, 32'(en_v), 0);
        check({tag, "_lock"}, 32'(lock), 0);
        check({tag, "_active"}, 32'(active), 0);
        check({tag, "_over"}, 32'(game_over), 0);
    endtask

    initial begin
        int f1, f2, y0, xs, nfall, n;

        #2 rst_n = 1'b0;
        step(); step();
        check_all_reset("reset");
        rst_n = 1'b1;
        step();

        // spawn and enter play
        ok_mode = OK_ALWAYS;
        spawn = 1'b1; step(); spawn = 1'b0;
        check("spawn_en_zero", 32'(en_v), 0);
        check("spawn_active", 32'(active), 1);
        step();
        check("spawn_x", 32'(ctrl_pos_x), 4);
        check("spawn_y", 32'(ctrl_pos_y), 0);
        check("spawn_rot", 32'(ctrl_rot), 0);
        $display("spawn: pos=(%0d,%0d,%0d) active=%0d", ctrl_pos_x, ctrl_pos_y, ctrl_rot, active);

        // left accepted then rejected
        btn_left = 1'b1; step(); btn_left = 1'b0;
        check("left_en", 32'(left_en), 1);
        step();
        check("left_ok_x", 32'(ctrl_pos_x), 3);
        ok_mode = OK_NEVER;
        btn_left = 1'b1; step(); btn_left = 1'b0;
        check("left_en2", 32'(left_en), 1);
        step();
        check("left_fail_x", 32'(ctrl_pos_x), 3);
        check("left_fail_active", 32'(active), 1);
        ok_mode = OK_ALWAYS;
        $display("left: x=%0d after reject", ctrl_pos_x);

        // gravity period and y increment
        wait_fall(f1);
        y0 = int'(ctrl_pos_y);
        step();
        check("grav_y1", 32'(ctrl_pos_y), 32'((y0 + 1) % 32));
        wait_fall(f2);
        check("grav_period", 32'(f2 - f1), 5);
        step();
        check("grav_y2", 32'(ctrl_pos_y), 32'((y0 + 2) % 32));
        $display("gravity: falls at %0d and %0d, y=%0d", f1, f2, ctrl_pos_y);

        // tick coincides with btn_right: tick wins
        step(); step(); step();
        xs = int'(ctrl_pos_x);
        btn_right = 1'b1; step(); btn_right = 1'b0;
        check("coinc_fall", 32'(fall_en), 1);
        check("coinc_right", 32'(right_en), 0);
        step();
        check("coinc_right2", 32'(right_en), 0);
        check("coinc_x", 32'(ctrl_pos_x), 32'(xs));
        $display("tick+right: x=%0d", ctrl_pos_x);

        // rotation wrap
        for (int i = 0; i < 3; i++) press_move(MV_ROT);
        check("rot_3", 32'(ctrl_rot), 3);
        press_move(MV_ROT);
        check("rot_wrap", 32'(ctrl_rot), 0);
        $display("rotate: rot=%0d", ctrl_rot);

        // x wrap on left from 0
        for (int i = 0; i < 3; i++) press_move(MV_LEFT);
        check("x_0", 32'(ctrl_pos_x), 0);
        press_move(MV_LEFT);
        check("x_wrap", 32'(ctrl_pos_x), 15);
        $display("left wrap: x=%0d", ctrl_pos_x);

        // failed fall locks
        ok_mode = OK_NEVER;
        wait_fall(f1);
        y0 = int'(ctrl_pos_y);
        step();
        check("fall_lock", 32'(lock), 1);
        check("fall_lock_y", 32'(ctrl_pos_y), 32'(y0));
        step();
        check("lock_once", 32'(lock), 0);
        check("lock_idle", 32'(active), 0);
        $display("fall fail: lock seen, y=%0d", ctrl_pos_y);

        // hard drop onto floor row 5
        ok_mode = OK_FLOOR; floor_row = 5;
        spawn = 1'b1; step(); spawn = 1'b0;
        step();
        btn_drop = 1'b1; step(); btn_drop = 1'b0;
        check("drop_en", 32'(drop_en), 1);
        nfall = 0; n = 0;
        while (!lock && n < 20) begin
            step();
            n++;
            if (fall_en) nfall++;
        end
        check("drop_lock", 32'(lock), 1);
        check("drop_y", 32'(ctrl_pos_y), 5);
        check("drop_fall_cycles", 32'(nfall), 6);
        step();
        check("drop_lock_once", 32'(lock), 0);
        $display("drop: y=5 reached, fall_en cycles=%0d", nfall);

        // spawn blocked -> game over, sticky
        ok_mode = OK_NEVER;
        spawn = 1'b1; step(); spawn = 1'b0;
        step();
        check("over_flag", 32'(game_over), 1);
        check("over_active", 32'(active), 0);
        ok_mode = OK_ALWAYS;
        spawn = 1'b1; btn_left = 1'b1; btn_drop = 1'b1; step();
        spawn = 1'b0; btn_left = 1'b0; btn_drop = 1'b0;
        step(); step();
        check("over_sticky", 32'(game_over), 1);
        check("over_x", 32'(ctrl_pos_x), 4);
        check("over_en", 32'(en_v), 0);
        $display("game over: sticky=%0d", game_over);

        // asynchronous reset in the middle of a drop
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        spawn = 1'b1; step(); spawn = 1'b0;
        step();
        btn_drop = 1'b1; step(); btn_drop = 1'b0;
        step(); step();
        check("middrop_fall", 32'(fall_en), 1);
        #2 rst_n = 1'b0;
        #1 check_all_reset("async_reset");
        $display("reset mid-drop: outputs cleared");
        step();
        rst_n = 1'b1;
        step();

        // randomized play, checked by the model every cycle
        ok_mode = OK_RANDOM;
        for (int i = 0; i < 3000; i++) begin
            rnd_ok     = ($urandom_range(0, 3) != 0);
            spawn      = ($urandom_range(0, 3) == 0);
            btn_left   = ($urandom_range(0, 7) == 0);
            btn_right  = ($urandom_range(0, 7) == 0);
            btn_down   = ($urandom_range(0, 9) == 0);
            btn_rotate = ($urandom_range(0, 7) == 0);
            btn_drop   = ($urandom_range(0, 19) == 0);
            rst_n      = !(game_over || ($urandom_range(0, 499) == 0));
            step();
        end
        {spawn, btn_left, btn_right, btn_down, btn_rotate, btn_drop} = '0;
        rst_n = 1'b1;
        step(); step();
        $display("random phase: 3000 cycles done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
